// File: rtl/rw_sched.sv
// ============================================================================
// Module   : rw_sched
// Brief    : Read/write command scheduler with write-drain watermarks and
//            bus-turnaround gaps. Optional macro STARVE_GUARD_EN bounds
//            same-direction bursts to MAX_BURST grants.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rw_sched #(
   parameter int ADRS_W    = 32,
   parameter int CNT_W     = 5,
   parameter int WR_HI     = 12,
   parameter int WR_LO     = 4,
   parameter int T_RTW     = 4,
   parameter int T_WTR     = 6,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_mt,
   input  logic              wr_mt,
   input  logic [ADRS_W-1:0] rd_adrs,
   input  logic [ADRS_W-1:0] wr_adrs,
   input  logic [CNT_W-1:0]  wr_cnt,
   input  logic              ready,
   output logic              rd_ld,
   output logic              wr_ld,
   output logic              valid,
   output logic              op,
   output logic [ADRS_W-1:0] adrs_out,
   output logic              drain,
   output logic              turn
);

   localparam int T_MAX = (T_RTW > T_WTR) ? T_RTW : T_WTR;
   localparam int TMR_W = $clog2(T_MAX + 1);
   localparam logic [TMR_W-1:0] C_RTW_LD = TMR_W'(T_RTW - 1);
   localparam logic [TMR_W-1:0] C_WTR_LD = TMR_W'(T_WTR - 1);
   localparam logic [CNT_W-1:0] C_WR_HI  = CNT_W'(WR_HI);
   localparam logic [CNT_W-1:0] C_WR_LO  = CNT_W'(WR_LO);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_TURN = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                tgt_wr_q, tgt_wr_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic                last_op_q, last_op_d;
   logic                drain_q, drain_d;
   logic                valid_q, valid_d;
   logic                op_q, op_d;
   logic [ADRS_W-1:0]   adrs_q, adrs_d;

   logic want_wr, want_rd;
   logic gnt_rd, gnt_wr;
   logic to_rd, to_wr;
   logic starve_rd_hit, starve_wr_hit, forced;

   assign want_wr = drain_q | (rd_mt & ~wr_mt);
   assign want_rd = ~rd_mt & ~drain_q;

   always_comb begin
      drain_d = drain_q;
      if (wr_mt || (wr_cnt <= C_WR_LO)) begin
         drain_d = 1'b0;
      end else if (wr_cnt >= C_WR_HI) begin
         drain_d = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      tgt_wr_d  = tgt_wr_q;
      timer_d   = timer_q;
      last_op_d = last_op_q;
      op_d      = op_q;
      adrs_d    = adrs_q;
      gnt_rd    = 1'b0;
      gnt_wr    = 1'b0;
      to_rd     = 1'b0;
      to_wr     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (want_rd) begin
               if (last_op_q) to_rd = 1'b1;
               else           state_d = S_RD;
            end else if (want_wr) begin
               if (!last_op_q) to_wr = 1'b1;
               else            state_d = S_WR;
            end
         end
         S_RD: begin
            // A forced entry owes one grant before watermark rules resume.
            if (want_wr && !forced) to_wr = 1'b1;
            else if (rd_mt)         state_d = S_IDLE;
            else if (starve_rd_hit) to_wr = 1'b1;
            else                    gnt_rd = ready;
         end
         S_WR: begin
            if (!want_wr && want_rd && !forced) to_rd = 1'b1;
            else if (wr_mt)                     state_d = S_IDLE;
            else if (starve_wr_hit)             to_rd = 1'b1;
            else                                gnt_wr = ready;
         end
         S_TURN: begin
            if (timer_q == '0) state_d = tgt_wr_q ? S_WR : S_RD;
            else               timer_d = timer_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (to_wr) begin
         state_d  = S_TURN;
         tgt_wr_d = 1'b1;
         timer_d  = C_RTW_LD;
      end else if (to_rd) begin
         state_d  = S_TURN;
         tgt_wr_d = 1'b0;
         timer_d  = C_WTR_LD;
      end

      valid_d = gnt_rd | gnt_wr;
      if (gnt_rd) begin
         last_op_d = 1'b0;
         op_d      = 1'b0;
         adrs_d    = rd_adrs;
      end else if (gnt_wr) begin
         last_op_d = 1'b1;
         op_d      = 1'b1;
         adrs_d    = wr_adrs;
      end
   end

`ifdef STARVE_GUARD_EN
   localparam int BST_W = $clog2(MAX_BURST + 1);
   localparam logic [BST_W-1:0] C_MAX_BURST = BST_W'(MAX_BURST);

   logic [BST_W-1:0] burst_q, burst_d;
   logic             force_q, force_d;
   logic             force_set;

   assign starve_rd_hit = (burst_q == C_MAX_BURST) & ~wr_mt;
   assign starve_wr_hit = (burst_q == C_MAX_BURST) & ~rd_mt;
   assign forced        = force_q;
   // A turn out of RD/WR that the watermark rules did not ask for came from the guard.
   assign force_set = (state_d == S_TURN) &&
                      (((state_q == S_RD) && !want_wr) ||
                       ((state_q == S_WR) && !(!want_wr && want_rd)));

   always_comb begin
      burst_d = burst_q;
      force_d = force_q;
      if ((state_d == S_IDLE) || ((state_d == S_TURN) && (state_q != S_TURN))) begin
         burst_d = '0;
      end else if ((gnt_rd || gnt_wr) && (burst_q != C_MAX_BURST)) begin
         burst_d = burst_q + 1'b1;
      end
      if (force_set) begin
         force_d = 1'b1;
      end else if (gnt_rd || gnt_wr || (state_d == S_IDLE)) begin
         force_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_q <= '0;
         force_q <= 1'b0;
      end else begin
         burst_q <= burst_d;
         force_q <= force_d;
      end
   end
`else
   assign starve_rd_hit = 1'b0;
   assign starve_wr_hit = 1'b0;
   assign forced        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         tgt_wr_q  <= 1'b0;
         timer_q   <= '0;
         last_op_q <= 1'b0;
         drain_q   <= 1'b0;
         valid_q   <= 1'b0;
         op_q      <= 1'b0;
         adrs_q    <= '0;
      end else begin
         state_q   <= state_d;
         tgt_wr_q  <= tgt_wr_d;
         timer_q   <= timer_d;
         last_op_q <= last_op_d;
         drain_q   <= drain_d;
         valid_q   <= valid_d;
         op_q      <= op_d;
         adrs_q    <= adrs_d;
      end
   end

   assign rd_ld    = gnt_rd;
   assign wr_ld    = gnt_wr;
   assign turn     = (state_q == S_TURN);
   assign valid    = valid_q;
   assign op       = op_q;
   assign adrs_out = adrs_q;
   assign drain    = drain_q;

endmodule

`default_nettype wire

// File: tb/tb_rw_sched.sv
// ============================================================================
// Module   : tb_rw_sched
// Brief    : Scoreboard bench for rw_sched with modelled read/write queues.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rw_sched;

   localparam int ADRS_W = 32;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              rd_mt, wr_mt, ready;
   logic [ADRS_W-1:0] rd_adrs, wr_adrs, adrs_out;
   logic [CNT_W-1:0]  wr_cnt;
   logic              rd_ld, wr_ld, valid, op, drain, turn;

   rw_sched dut (
      .clk(clk), .rst(rst), .rd_mt(rd_mt), .wr_mt(wr_mt),
      .rd_adrs(rd_adrs), .wr_adrs(wr_adrs), .wr_cnt(wr_cnt), .ready(ready),
      .rd_ld(rd_ld), .wr_ld(wr_ld), .valid(valid), .op(op),
      .adrs_out(adrs_out), .drain(drain), .turn(turn)
   );

   always #5 clk = ~clk;

   // Show-ahead source queues feeding the scheduler.
   logic [31:0] rd_mem [0:63];
   logic [31:0] wr_mem [0:63];
   int rd_hd = 0, rd_tl = 0, wr_hd = 0, wr_tl = 0;

   assign rd_mt   = (rd_hd == rd_tl);
   assign wr_mt   = (wr_hd == wr_tl);
   assign rd_adrs = rd_mem[rd_hd[5:0]];
   assign wr_adrs = wr_mem[wr_hd[5:0]];
   assign wr_cnt  = CNT_W'(wr_tl - wr_hd);

   always @(posedge clk) begin
      if (rd_ld) rd_hd <= rd_hd + 1;
      if (wr_ld) wr_hd <= wr_hd + 1;
   end

   typedef struct packed {
      logic        op;
      logic [31:0] a;
   } cmd_t;

   cmd_t exp_q[$];
   int   turn_lens[$];
   int   turn_run = 0;
   int   n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every issued command must match the head of the expected queue.
   always @(negedge clk) begin
      cmd_t e;
      if (rst) begin
         if (valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_unexpected: got op=%0d adrs=%0h, expected no command", op, adrs_out);
            end else begin
               e = exp_q.pop_front();
               chk("sb_op", {31'd0, op}, {31'd0, e.op});
               chk("sb_adrs", adrs_out, e.a);
            end
         end
         chk("ld_exclusive", {31'd0, rd_ld & wr_ld}, 32'd0);
         chk("pop_empty", {31'd0, (rd_ld & rd_mt) | (wr_ld & wr_mt)}, 32'd0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         turn_run = 0;
      end else if (turn) begin
         turn_run++;
      end else if (turn_run != 0) begin
         turn_lens.push_back(turn_run);
         turn_run = 0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_rd(input logic [31:0] a, input bit expect_it);
      rd_mem[rd_tl] = a;
      rd_tl++;
      if (expect_it) exp_q.push_back('{op: 1'b0, a: a});
   endtask

   task automatic push_wr(input logic [31:0] a);
      wr_mem[wr_tl] = a;
      wr_tl++;
   endtask

   task automatic exp_cmd(input logic o, input logic [31:0] a);
      exp_q.push_back('{op: o, a: a});
   endtask

   task automatic settle(input string name);
      int done = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (rd_mt && wr_mt && exp_q.size() == 0 && !turn && !valid) begin
            done = 1;
            break;
         end
      end
      chk({name, "_settle"}, done, 1);
      chk({name, "_sb_drained"}, exp_q.size(), 0);
      exp_q.delete();
      cyc(2);
   endtask

   task automatic check_turns(input string name, input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int n);
      int ev[5];
      ev = '{e0, e1, e2, e3, e4};
      chk({name, "_turn_count"}, turn_lens.size(), n);
      for (int i = 0; i < n && i < turn_lens.size(); i++)
         chk({name, "_turn_len"}, turn_lens[i], ev[i]);
      turn_lens.delete();
   endtask

   initial begin
      logic [5:0] pat_ld, pat_v, pat_t;
      for (int i = 0; i < 64; i++) begin
         rd_mem[i] = '0;
         wr_mem[i] = '0;
      end
      ready = 1'b1;
      cyc(2);

      // Reset values
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_op", {31'd0, op}, 0);
      chk("rst_adrs", adrs_out, 0);
      chk("rst_drain_turn", {30'd0, drain, turn}, 0);
      chk("rst_ld", {30'd0, rd_ld, wr_ld}, 0);
      rst = 1'b1;
      cyc(2);

      // Three reads: pops on cycles 1..3, commands one cycle later
      push_rd(32'h100, 1);
      push_rd(32'h104, 1);
      push_rd(32'h108, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat_ld[i] = rd_ld;
         pat_v[i]  = valid;
      end
      chk("rd3_ld_pattern", {26'd0, pat_ld}, 32'b001110);
      chk("rd3_valid_pattern", {26'd0, pat_v}, 32'b011100);
      cyc(1);
      settle("rd3");
      check_turns("rd3", 0, 0, 0, 0, 0, 0);

      // Write drain: 12th write arrives while reading
      for (int i = 0; i < 11; i++) push_wr(32'h1000 + 32'(4 * i));
      for (int i = 0; i < 10; i++) push_rd(32'h2000 + 32'(4 * i), 0);
      for (int i = 0; i < 3; i++)  exp_cmd(1'b0, 32'h2000 + 32'(4 * i));
      for (int i = 0; i < 9; i++)  exp_cmd(1'b1, 32'h1000 + 32'(4 * i));
      for (int i = 3; i < 10; i++) exp_cmd(1'b0, 32'h2000 + 32'(4 * i));
      for (int i = 9; i < 12; i++) exp_cmd(1'b1, 32'h1000 + 32'(4 * i));
      cyc(3);
      push_wr(32'h1000 + 32'(4 * 11));
      @(negedge clk);
      chk("drain_before", {31'd0, drain}, 0);
      @(negedge clk);
      chk("drain_set", {31'd0, drain}, 1);
      chk("drain_turn_pending", {31'd0, turn}, 0);
      settle("drain");
      chk("drain_cleared", {31'd0, drain}, 0);
      check_turns("drain", 4, 6, 4, 0, 0, 3);

      // ready 1,0,1 in RD after a write->read turnaround
      push_rd(32'h300, 1);
      push_rd(32'h304, 1);
      push_rd(32'h308, 1);
      cyc(8);
      ready = 1'b0;
      @(negedge clk);
      chk("rdy0_no_pop", {31'd0, rd_ld}, 0);
      chk("rdy0_state_holds", {31'd0, turn}, 0);
      cyc(1);
      ready = 1'b1;
      @(negedge clk);
      chk("rdy0_no_valid", {31'd0, valid}, 0);
      chk("rdy0_adrs_hold", adrs_out, 32'h300);
      chk("rdy1_pop", {31'd0, rd_ld}, 1);
      settle("rdy");
      check_turns("rdy", 6, 0, 0, 0, 0, 1);

      // Both queues empty: nothing moves
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_quiet", {28'd0, valid, rd_ld, wr_ld, turn}, 0);
      end
      cyc(1);

      // Single write after reset needs a read->write turnaround
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      push_wr(32'h4000);
      exp_cmd(1'b1, 32'h4000);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat_ld[i] = wr_ld;
         pat_t[i]  = turn;
      end
      chk("wr1_ld_pattern", {26'd0, pat_ld}, 32'b100000);
      chk("wr1_turn_pattern", {26'd0, pat_t}, 32'b011110);
      cyc(1);
      settle("wr1");
      check_turns("wr1", 4, 0, 0, 0, 0, 1);

      // Reset during a write->read turnaround
      push_rd(32'h5000, 1);
      cyc(2);
      @(negedge clk);
      chk("turn_before_rst", {31'd0, turn}, 1);
      cyc(1);
      rst = 1'b0;
      #1;
      chk("rst_async_flags", {26'd0, valid, op, drain, turn, rd_ld, wr_ld}, 0);
      chk("rst_async_adrs", adrs_out, 0);
      cyc(1);
      turn_lens.delete();
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_c0", {30'd0, rd_ld, turn}, 0);
      @(negedge clk);
      chk("post_rst_c1", {30'd0, rd_ld, turn}, 32'b10);
      cyc(1);
      settle("post_rst");
      check_turns("post_rst", 0, 0, 0, 0, 0, 0);

`ifdef STARVE_GUARD_EN
      // Drain active with reads waiting: guard forces one read after 8 writes
      for (int i = 0; i < 14; i++) push_wr(32'h6000 + 32'(4 * i));
      for (int i = 0; i < 8; i++)  exp_cmd(1'b1, 32'h6000 + 32'(4 * i));
      exp_cmd(1'b0, 32'h7000);
      for (int i = 8; i < 11; i++) exp_cmd(1'b1, 32'h6000 + 32'(4 * i));
      exp_cmd(1'b0, 32'h7004);
      for (int i = 11; i < 14; i++) exp_cmd(1'b1, 32'h6000 + 32'(4 * i));
      cyc(2);
      push_rd(32'h7000, 0);
      push_rd(32'h7004, 0);
      settle("starve");
      check_turns("starve", 4, 6, 4, 6, 4, 5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
